dot_product_mac: RTL

Parametrised, pipelined, multi-lane multiply-accumulate engine that computes an unsigned dot product over a programmable number of input beats. Each beat supplies LANES operand pairs. The block sums their products into one accumulator and presents the result through a valid/ready output handshake. It is the successor to the single-lane En/Clr MAC and sits between an operand streamer and the result consumer.

---
 rtl/dot_product_mac.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dot_product_mac.sv
// dot_product_mac: pipelined multi-lane unsigned multiply-accumulate engine.
// Each accepted beat supplies LANES operand pairs. Stage 1 registers the lane
// products and stage 2 adds their sum into a single accumulator. The result is
// offered on a valid/ready output.
// Optional build macro: MAC_SATURATE_EN. When it is defined, the accumulator
// clamps to all-ones on overflow. When it is not defined, the accumulator wraps.
//
// Handshakes:
//   input  side: a beat transfers on a rising edge where in_valid && in_ready.
//                in_ready depends only on state (high in ACCUM).
//   output side: the result transfers on a rising edge where
//                out_valid && out_ready. Cout/overflow stay stable while
//                out_valid is high.
module dot_product_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int ACC_WIDTH  = DATA_WIDTH * 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Clr,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] Ain,
    input  logic [LANES*DATA_WIDTH-1:0] Bin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        Cout,
    output logic                        busy,
    output logic                        overflow,
    output logic [1:0]                  state_dbg
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    // The lane sum needs enough width that no carry between lanes is lost.
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    // The adder is one bit wider than both operands, so any carry out of
    // the accumulator stays visible.
    localparam int EXT_W  = ((SUM_W > ACC_WIDTH) ? SUM_W : ACC_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [PROD_W-1:0]      prod_q [LANES];
    logic                   prod_valid;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   acc_ovf;

    logic                   beat_accept;
    logic [SUM_W-1:0]       lane_sum;
    logic [EXT_W-1:0]       acc_ext;
    logic                   add_carry;
    logic [ACC_WIDTH-1:0]   acc_next;

    assign in_ready    = (state == S_ACCUM);
    assign beat_accept = in_valid && in_ready;
    assign out_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign Cout        = acc;
    assign overflow    = acc_ovf;
    assign state_dbg   = state;

    // Stage-2 adder: sum the lane products at full width, then add the sum into the accumulator.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(prod_q[i]);
        end
        acc_ext   = EXT_W'(acc) + EXT_W'(lane_sum);
        add_carry = |acc_ext[EXT_W-1:ACC_WIDTH];
`ifdef MAC_SATURATE_EN
        // Once the accumulator has clamped, it stays at all-ones until the run ends.
        acc_next  = (add_carry || acc_ovf) ? '1 : acc_ext[ACC_WIDTH-1:0];
`else
        acc_next  = acc_ext[ACC_WIDTH-1:0];
`endif
    end

    // Run-control FSM: IDLE -> ACCUM -> DRAIN -> DONE -> IDLE (len==0 goes straight to DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
        end else if (Clr) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            beat_cnt <= len;
                            state    <= S_ACCUM;
                        end else begin
                            state    <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat_accept) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == LEN_WIDTH'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                // The last product is absorbed by stage 2 during this cycle.
                S_DRAIN: state <= S_DONE;
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage 1: register one product per lane, with a flag marking the beat as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else if (Clr) begin
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= beat_accept;
            if (beat_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_q[i] <= PROD_W'(Ain[i*DATA_WIDTH +: DATA_WIDTH])
                               * PROD_W'(Bin[i*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end

    // Stage 2: accumulate the lane sum and record any carry out in the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (Clr) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (state == S_IDLE && start) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (prod_valid) begin
            acc     <= acc_next;
            acc_ovf <= acc_ovf | add_carry;
        end
    end

endmodule
